// File: rtl/ldl_hot2bin_pkg.sv
// Shared types and helpers for the hot-to-binary request arbiter.
package ldl_hot2bin_pkg;

    // Grant ordering policy.
    typedef enum logic {
        LDL_H2B_FIXED = 1'b0,
        LDL_H2B_RR    = 1'b1
    } ldl_h2b_mode_e;

    // Widest request vector the helpers below handle.
    localparam int unsigned LDL_H2B_MAX_HOT = 64;

    // One-hot of an index; indices at or beyond LDL_H2B_MAX_HOT yield zero.
    function automatic logic [LDL_H2B_MAX_HOT-1:0] ldl_h2b_onehot(input int unsigned idx);
        logic [LDL_H2B_MAX_HOT-1:0] vec;
        vec = '0;
        if (idx < LDL_H2B_MAX_HOT) begin
            vec[idx] = 1'b1;
        end
        return vec;
    endfunction

    // Number of set bits in a vector.
    function automatic int unsigned ldl_h2b_popcount(input logic [LDL_H2B_MAX_HOT-1:0] vec);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < LDL_H2B_MAX_HOT; i++) begin
            cnt = cnt + 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/ldl_hot2bin_arb_rr_pick.sv
// Combinational winner selection: first set bit at or above ptr, else lowest set bit.
module ldl_rr_pick
    import ldl_hot2bin_pkg::*;
#(
    parameter int unsigned BIN_WIDTH = 4,
    parameter int unsigned HOT_WIDTH = 32'd1 << BIN_WIDTH
) (
    input  logic [HOT_WIDTH-1:0] pend,
    input  logic [BIN_WIDTH-1:0] ptr,
    output logic [BIN_WIDTH-1:0] winner_c,
    output logic                 found_c
);

    logic [HOT_WIDTH-1:0] masked;
    logic                 hit_hi;
    logic                 hit_lo;
    logic [BIN_WIDTH-1:0] idx_hi;
    logic [BIN_WIDTH-1:0] idx_lo;

    // Keep only requests at or above the pointer for the first scan.
    always_comb begin
        masked = '0;
        for (int i = 0; i < int'(HOT_WIDTH); i++) begin
            masked[i] = pend[i] & (BIN_WIDTH'(i) >= ptr);
        end
    end

    // Two lowest-index scans; the masked hit wins, the unmasked one covers wrap-around.
    always_comb begin
        hit_hi = 1'b0;
        hit_lo = 1'b0;
        idx_hi = '0;
        idx_lo = '0;
        for (int i = 0; i < int'(HOT_WIDTH); i++) begin
            if (masked[i] && !hit_hi) begin
                hit_hi = 1'b1;
                idx_hi = BIN_WIDTH'(i);
            end
            if (pend[i] && !hit_lo) begin
                hit_lo = 1'b1;
                idx_lo = BIN_WIDTH'(i);
            end
        end
        found_c  = hit_lo;
        winner_c = hit_hi ? idx_hi : idx_lo;
    end

endmodule

// File: rtl/ldl_hot2bin_arb.sv
// Captures request pulses into a pending vector and hands out one binary index
// per valid/ready transfer, in fixed-priority or round-robin order.
module ldl_hot2bin_arb
    import ldl_hot2bin_pkg::*;
#(
    parameter int unsigned   BIN_WIDTH = 4,
    parameter int unsigned   HOT_WIDTH = 32'd1 << BIN_WIDTH,
    parameter ldl_h2b_mode_e MODE      = LDL_H2B_RR
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic [HOT_WIDTH-1:0] req,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIN_WIDTH-1:0] out_bin,
    output logic [HOT_WIDTH-1:0] out_hot,
    output logic [BIN_WIDTH:0]   pend_cnt,
    output logic                 busy
);

    localparam int unsigned CNT_W = BIN_WIDTH + 1;

    // Reject request widths the index or the helper functions cannot represent.
    if (HOT_WIDTH < 2 || HOT_WIDTH > (32'd1 << BIN_WIDTH) || HOT_WIDTH > LDL_H2B_MAX_HOT) begin : g_bad_width
        $error("ldl_hot2bin_arb: HOT_WIDTH out of range for BIN_WIDTH");
    end

    logic [HOT_WIDTH-1:0] pend_q;
    logic [BIN_WIDTH-1:0] ptr_q;

    logic [BIN_WIDTH-1:0] winner_c;
    logic                 found_c;
    logic                 load_c;
    logic [HOT_WIDTH-1:0] win_hot_c;
    logic [HOT_WIDTH-1:0] clr_vec_c;
    logic [HOT_WIDTH-1:0] pend_nxt_c;
    logic [BIN_WIDTH-1:0] ptr_nxt_c;

    // Winner is chosen from registered pending bits only; fresh requests wait a cycle.
    ldl_rr_pick #(
        .BIN_WIDTH (BIN_WIDTH),
        .HOT_WIDTH (HOT_WIDTH)
    ) u_pick (
        .pend     (pend_q),
        .ptr      (ptr_q),
        .winner_c (winner_c),
        .found_c  (found_c)
    );

    // Load when something is pending and the output slot is free or being drained.
    always_comb begin
        load_c     = (|pend_q) & (~out_valid | out_ready);
        win_hot_c  = HOT_WIDTH'(ldl_h2b_onehot(32'(winner_c)));
        clr_vec_c  = load_c ? win_hot_c : '0;
        pend_nxt_c = (pend_q & ~clr_vec_c) | req;
        ptr_nxt_c  = ptr_q;
        if (MODE == LDL_H2B_RR && load_c) begin
            ptr_nxt_c = (32'(winner_c) == HOT_WIDTH - 1) ? '0 : winner_c + BIN_WIDTH'(1);
        end
    end

    // Pending vector: a new request on the bit being granted keeps it set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else if (flush) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_nxt_c;
        end
    end

    // Output holding register; out_bin keeps its last value after an accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_hot   <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_hot   <= '0;
        end else if (load_c) begin
            out_valid <= 1'b1;
            out_bin   <= winner_c;
            out_hot   <= win_hot_c;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_hot   <= '0;
        end
    end

    // Round-robin pointer: one past the last winner, wrapping at HOT_WIDTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (flush) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_nxt_c;
        end
    end

    // Status derived from registers only.
    always_comb begin
        pend_cnt = CNT_W'(ldl_h2b_popcount(LDL_H2B_MAX_HOT'(pend_q)));
        busy     = (|pend_q) | out_valid;
    end

endmodule

// File: tb/tb_ldl_hot2bin_arb.sv
// Bench for ldl_hot2bin_arb: a round-robin and a fixed-priority instance share
// stimulus; each is compared every cycle against a rotation-search reference.
module tb_ldl_hot2bin_arb;
    import ldl_hot2bin_pkg::*;

    localparam int unsigned BW = 4;
    localparam int unsigned HW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          out_ready;
    logic [HW-1:0] req;

    logic          rr_valid, fx_valid;
    logic [BW-1:0] rr_bin, fx_bin;
    logic [HW-1:0] rr_hot, fx_hot;
    logic [BW:0]   rr_cnt, fx_cnt;
    logic          rr_busy, fx_busy;

    int checks = 0;
    int errors = 0;

    // Reference state: index 0 = round-robin instance, 1 = fixed-priority instance.
    logic [HW-1:0] m_pend [2];
    logic          m_valid[2];
    int            m_bin  [2];
    int            m_ptr  [2];

    always #5 clk = ~clk;

    ldl_hot2bin_arb #(.BIN_WIDTH(BW), .HOT_WIDTH(HW), .MODE(LDL_H2B_RR)) dut_rr (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
        .out_valid(rr_valid), .out_ready(out_ready), .out_bin(rr_bin),
        .out_hot(rr_hot), .pend_cnt(rr_cnt), .busy(rr_busy)
    );

    ldl_hot2bin_arb #(.BIN_WIDTH(BW), .HOT_WIDTH(HW), .MODE(LDL_H2B_FIXED)) dut_fx (
        .clk(clk), .rst_n(rst_n), .flush(flush), .req(req),
        .out_valid(fx_valid), .out_ready(out_ready), .out_bin(fx_bin),
        .out_hot(fx_hot), .pend_cnt(fx_cnt), .busy(fx_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Walk forward from start, wrapping, and return the first pending index.
    function automatic int first_from(input logic [HW-1:0] p, input int start);
        for (int j = 0; j < int'(HW); j++) begin
            if (p[(start + j) % int'(HW)]) return (start + j) % int'(HW);
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pend[k]  = '0;
            m_valid[k] = 1'b0;
            m_bin[k]   = 0;
            m_ptr[k]   = 0;
        end
    endtask

    // Advance the reference by one clock edge given the inputs seen at that edge.
    task automatic model_step(input logic [HW-1:0] r, input logic rdy, input logic fl);
        int   w;
        logic ld;
        for (int k = 0; k < 2; k++) begin
            if (fl) begin
                m_pend[k]  = '0;
                m_valid[k] = 1'b0;
                m_ptr[k]   = 0;
            end else begin
                ld = (m_pend[k] != '0) && (!m_valid[k] || rdy);
                if (ld) begin
                    w = first_from(m_pend[k], (k == 0) ? m_ptr[k] : 0);
                    m_pend[k][w] = 1'b0;
                    m_bin[k]     = w;
                    m_valid[k]   = 1'b1;
                    if (k == 0) m_ptr[k] = (w + 1) % int'(HW);
                end else if (m_valid[k] && rdy) begin
                    m_valid[k] = 1'b0;
                end
                m_pend[k] = m_pend[k] | r;
            end
        end
    endtask

    task automatic check_all();
        logic [31:0] exp_hot;
        for (int k = 0; k < 2; k++) begin
            exp_hot = m_valid[k] ? (32'd1 << m_bin[k]) : 32'd0;
            chk((k == 0) ? "rr.valid" : "fx.valid", 32'((k == 0) ? rr_valid : fx_valid), 32'(m_valid[k]));
            chk((k == 0) ? "rr.hot" : "fx.hot", 32'((k == 0) ? rr_hot : fx_hot), exp_hot);
            chk((k == 0) ? "rr.pend_cnt" : "fx.pend_cnt", 32'((k == 0) ? rr_cnt : fx_cnt), 32'($countones(m_pend[k])));
            chk((k == 0) ? "rr.busy" : "fx.busy", 32'((k == 0) ? rr_busy : fx_busy),
                32'((m_pend[k] != '0) || m_valid[k]));
            if (m_valid[k]) begin
                chk((k == 0) ? "rr.bin" : "fx.bin", 32'((k == 0) ? rr_bin : fx_bin), 32'(m_bin[k]));
            end
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance the model, compare.
    task automatic cycle(input logic [HW-1:0] r, input logic rdy, input logic fl);
        req       = r;
        out_ready = rdy;
        flush     = fl;
        @(posedge clk);
        model_step(r, rdy, fl);
        #1;
        check_all();
    endtask

    initial begin
        int          rr_exp[4];
        logic [HW-1:0] r;
        rr_exp = '{0, 5, 10, 15};

        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0; req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("reset.rr_bin", 32'(rr_bin), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Idle after reset.
        repeat (5) cycle('0, 1'b0, 1'b0);

        // Round-robin walk of 0x8421, then wrap back to pointer 0.
        cycle(16'h8421, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cycle('0, 1'b1, 1'b0);
            chk("rr_seq.bin", 32'(rr_bin), 32'(rr_exp[i]));
            chk("rr_seq.valid", 32'(rr_valid), 32'd1);
        end
        cycle('0, 1'b1, 1'b0);
        chk("rr_seq.drained", 32'(rr_valid), 32'd0);
        cycle(16'h4002, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        chk("rr_wrap.first", 32'(rr_bin), 32'd1);
        cycle('0, 1'b1, 1'b0);
        chk("rr_wrap.second", 32'(rr_bin), 32'd14);
        cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b1);

        // Fixed priority with a stalled consumer.
        cycle(16'h0300, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        cycle(16'h0001, 1'b0, 1'b0);
        chk("fx_stall.bin", 32'(fx_bin), 32'd8);
        chk("fx_stall.valid", 32'(fx_valid), 32'd1);
        cycle('0, 1'b1, 1'b0);
        chk("fx_after.bin0", 32'(fx_bin), 32'd0);
        cycle('0, 1'b1, 1'b0);
        chk("fx_after.bin9", 32'(fx_bin), 32'd9);
        cycle('0, 1'b1, 1'b0);
        chk("fx_after.idle", 32'(fx_valid), 32'd0);
        cycle('0, 1'b0, 1'b1);

        // Continuous requests on 2 and 3 must alternate under round-robin.
        cycle(16'h000C, 1'b1, 1'b0);
        for (int i = 1; i <= 4; i++) begin
            cycle(16'h000C, 1'b1, 1'b0);
            chk("rr_starve.bin", 32'(rr_bin), (i % 2 == 1) ? 32'd2 : 32'd3);
        end
        repeat (3) cycle('0, 1'b1, 1'b0);
        cycle('0, 1'b0, 1'b1);

        // Re-request of the index being loaded stays pending and is granted again.
        cycle(16'h0010, 1'b0, 1'b0);
        cycle(16'h0010, 1'b0, 1'b0);
        chk("setwin.bin", 32'(rr_bin), 32'd4);
        chk("setwin.cnt", 32'(rr_cnt), 32'd1);
        cycle('0, 1'b1, 1'b0);
        chk("setwin.regrant", 32'(rr_bin), 32'd4);
        chk("setwin.valid", 32'(rr_valid), 32'd1);
        chk("setwin.cnt0", 32'(rr_cnt), 32'd0);
        cycle('0, 1'b1, 1'b0);
        chk("setwin.idle", 32'(rr_valid), 32'd0);

        // Flush with a held output, pending 0xF0 and a same-cycle request.
        cycle(16'h00F1, 1'b0, 1'b0);
        cycle('0, 1'b0, 1'b0);
        chk("flush.pre_valid", 32'(rr_valid), 32'd1);
        chk("flush.pre_cnt", 32'(rr_cnt), 32'd4);
        cycle(16'h0001, 1'b0, 1'b1);
        chk("flush.valid", 32'(rr_valid), 32'd0);
        chk("flush.cnt", 32'(rr_cnt), 32'd0);
        chk("flush.busy", 32'(rr_busy), 32'd0);
        chk("flush.hot", 32'(rr_hot), 32'd0);
        cycle('0, 1'b0, 1'b0);
        chk("flush.dropped", 32'(rr_busy), 32'd0);

        // Asynchronous reset in the middle of a handshake.
        cycle(16'h00F1, 1'b1, 1'b0);
        cycle('0, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("areset.valid", 32'(rr_valid), 32'd0);
        chk("areset.cnt", 32'(rr_cnt), 32'd0);
        chk("areset.busy", 32'(fx_busy), 32'd0);
        chk("areset.hot", 32'(rr_hot), 32'd0);
        model_reset();
        @(negedge clk) rst_n = 1'b1;
        cycle('0, 1'b1, 1'b0);

        // Random traffic: mostly-ready consumer, then a mostly-stalled one.
        for (int i = 0; i < 500; i++) begin
            r = HW'($urandom & $urandom & $urandom);
            cycle(r, $urandom_range(0, 3) != 0, $urandom_range(0, 39) == 0);
        end
        for (int i = 0; i < 300; i++) begin
            r = HW'($urandom & $urandom);
            cycle(r, $urandom_range(0, 3) == 0, $urandom_range(0, 59) == 0);
        end
        repeat (40) cycle('0, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
